// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the controller, ghosts and display.
// Pure declarations; no timing or flow control of its own.
package game_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DEATH = 2'd2,
        ST_END   = 2'd3
    } state_t;

    typedef enum logic {
        MODE_SCATTER = 1'b0,
        MODE_CHASE   = 1'b1
    } mode_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    function automatic logic is_start_key(input logic [7:0] key);
        return (key == KEY_A) || (key == KEY_D) || (key == KEY_S) || (key == KEY_W);
    endfunction

endpackage

// File: rtl/game_ctrl_mode_timer.sv
// Scatter/chase phase timer; advances one count per frame while run is high.
// Phase flop updates on the frame edge; clear wins over run, no backpressure.
module mode_timer
    import game_pkg::*;
#(
    parameter int SCATTER_FRAMES = 420,
    parameter int CHASE_FRAMES   = 1200
) (
    input  logic  frame_clk,
    input  logic  Reset,
    input  logic  run,
    input  logic  clear,
    output mode_t phase
);

    localparam logic [11:0] SCATTER_LAST = 12'(SCATTER_FRAMES - 1);
    localparam logic [11:0] CHASE_LAST   = 12'(CHASE_FRAMES - 1);

    logic [11:0] count;
    logic [11:0] last;

    assign last = (phase == MODE_SCATTER) ? SCATTER_LAST : CHASE_LAST;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
            phase <= MODE_SCATTER;
        end else if (clear) begin
            count <= '0;
            phase <= MODE_SCATTER;
        end else if (run) begin
            // count holds frames already spent in this phase
            if (count == last) begin
                count <= '0;
                phase <= (phase == MODE_SCATTER) ? MODE_CHASE : MODE_SCATTER;
            end else begin
                count <= count + 12'd1;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow FSM: READY/PLAY/DEATH/END, lives, win flag, respawn pulse, patrol masks.
// Every output is a flop (patrol is the phase flop masked by a constant); 1-frame latency.
module game_ctrl
    import game_pkg::*;
#(
    parameter int         LIVES_INIT        = 3,
    parameter int         DEATH_FRAMES      = 120,
    parameter int         SCATTER_FRAMES    = 420,
    parameter int         CHASE_FRAMES      = 1200,
    parameter logic [3:0] CHASE_ALWAYS_MASK = 4'b0001
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [3:0] caught_check,
    input  logic       all_eaten,
    output logic [1:0] state,
    output logic [3:0] patrol,
    output logic [1:0] lives,
    output logic       won,
    output logic       respawn
);

    localparam int            DW         = $clog2(DEATH_FRAMES + 1);
    localparam logic [DW-1:0] DEATH_LOAD = DW'(DEATH_FRAMES);
    localparam logic [1:0]    LIVES_RST  = 2'(LIVES_INIT);

    state_t        st;
    logic [DW-1:0] death_cnt;
    logic          death_done;
    logic          respawn_next;
    mode_t         phase;

    assign death_done = (death_cnt <= DW'(1));

    // Decided a frame early so the timer is back in scatter during the respawn frame.
    assign respawn_next = ((st == ST_END)   && (keycode == KEY_ENTER)) ||
                          ((st == ST_DEATH) && death_done && (lives != 2'd0));

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            st        <= ST_READY;
            lives     <= LIVES_RST;
            won       <= 1'b0;
            respawn   <= 1'b0;
            death_cnt <= '0;
        end else begin
            respawn <= respawn_next;
            case (st)
                ST_READY: begin
                    if (is_start_key(keycode)) st <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (all_eaten) begin
                        st  <= ST_END;
                        won <= 1'b1;
                    end else if (caught_check != 4'b0000) begin
                        st        <= ST_DEATH;
                        death_cnt <= DEATH_LOAD;
                        if (lives != 2'd0) lives <= lives - 2'd1;
                    end
                end
                ST_DEATH: begin
                    death_cnt <= death_cnt - DW'(1);
                    if (death_done) begin
                        if (lives != 2'd0) begin
                            st <= ST_READY;
                        end else begin
                            st  <= ST_END;
                            won <= 1'b0;
                        end
                    end
                end
                ST_END: begin
                    if (keycode == KEY_ENTER) begin
                        st    <= ST_READY;
                        lives <= LIVES_RST;
                        won   <= 1'b0;
                    end
                end
                default: st <= ST_READY;
            endcase
        end
    end

    mode_timer #(
        .SCATTER_FRAMES (SCATTER_FRAMES),
        .CHASE_FRAMES   (CHASE_FRAMES)
    ) u_mode_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .run       (st == ST_PLAY),
        .clear     (respawn_next),
        .phase     (phase)
    );

    assign state  = st;
    assign patrol = (phase == MODE_SCATTER) ? ~CHASE_ALWAYS_MASK : 4'b0000;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboarded bench for game_ctrl: a frame-level reference model queues expected
// outputs as each frame's inputs are driven; they are popped and compared after the edge.
module tb_game_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [3:0] caught_check;
    logic       all_eaten;
    logic [1:0] state;
    logic [3:0] patrol;
    logic [1:0] lives;
    logic       won;
    logic       respawn;

    game_ctrl dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .caught_check (caught_check),
        .all_eaten    (all_eaten),
        .state        (state),
        .patrol       (patrol),
        .lives        (lives),
        .won          (won),
        .respawn      (respawn)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] pat;
        logic [1:0] lv;
        logic       w;
        logic       r;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    int m_state, m_lives, m_dleft, m_elapsed;
    bit m_won, m_resp, m_chase;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_won = 0; m_resp = 0;
        m_chase = 0; m_elapsed = 0; m_dleft = 0;
    endtask

    task automatic model_edge(input logic [7:0] k, input logic [3:0] c, input logic e);
        int  prev;
        bit  resp_n;
        prev   = m_state;
        resp_n = 0;
        case (m_state)
            0: if (k == 8'h04 || k == 8'h07 || k == 8'h16 || k == 8'h1A) m_state = 1;
            1: begin
                if (e) begin
                    m_state = 3; m_won = 1;
                end else if (c != 4'b0) begin
                    m_state = 2; m_lives = m_lives - 1; m_dleft = 120;
                end
            end
            2: begin
                m_dleft = m_dleft - 1;
                if (m_dleft == 0) begin
                    if (m_lives > 0) begin
                        m_state = 0; resp_n = 1;
                    end else begin
                        m_state = 3; m_won = 0;
                    end
                end
            end
            default: if (k == 8'h28) begin
                m_state = 0; m_lives = 3; m_won = 0; resp_n = 1;
            end
        endcase
        m_resp = resp_n;
        if (resp_n) begin
            m_chase = 0; m_elapsed = 0;
        end else if (prev == 1) begin
            m_elapsed++;
            if (m_elapsed == (m_chase ? 1200 : 420)) begin
                m_chase = !m_chase; m_elapsed = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.st  = 2'(m_state);
        x.pat = m_chase ? 4'h0 : 4'hE;
        x.lv  = 2'(m_lives);
        x.w   = m_won;
        x.r   = m_resp;
        return x;
    endfunction

    task automatic step(input logic [7:0] k, input logic [3:0] c, input logic e);
        exp_t x;
        keycode = k; caught_check = c; all_eaten = e;
        model_edge(k, c, e);
        q.push_back(model_out());
        @(posedge frame_clk);
        #1;
        x = q.pop_front();
        chk("sb_state",   32'(state),   32'(x.st));
        chk("sb_patrol",  32'(patrol),  32'(x.pat));
        chk("sb_lives",   32'(lives),   32'(x.lv));
        chk("sb_won",     32'(won),     32'(x.w));
        chk("sb_respawn", 32'(respawn), 32'(x.r));
    endtask

    task automatic idle(input int n, input logic [3:0] c);
        for (int i = 0; i < n; i++) step(8'h00, c, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},   32'(state),   32'd0);
        chk({tag, "_lives"},   32'(lives),   32'd3);
        chk({tag, "_won"},     32'(won),     32'd0);
        chk({tag, "_respawn"}, 32'(respawn), 32'd0);
        chk({tag, "_patrol"},  32'(patrol),  32'hE);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; keycode = 8'h00; caught_check = 4'b0; all_eaten = 1'b0;
        model_reset();
        #23;
        chk_reset_vals("rst");
        Reset = 1'b0;
        idle(1, 4'b0);

        // start with W, then scatter/chase boundaries
        step(8'h1A, 4'b0, 1'b0);
        chk("start_state", 32'(state), 32'd1);
        chk("start_patrol", 32'(patrol), 32'hE);
        idle(419, 4'b0);
        chk("scatter_419", 32'(patrol), 32'hE);
        idle(1, 4'b0);
        chk("chase_420", 32'(patrol), 32'h0);
        idle(1199, 4'b0);
        chk("chase_1199", 32'(patrol), 32'h0);
        idle(1, 4'b0);
        chk("scatter_back", 32'(patrol), 32'hE);

        // into chase, then a held catch
        idle(425, 4'b0);
        chk("pre_catch_chase", 32'(patrol), 32'h0);
        for (int i = 0; i < 200; i++) begin
            step(8'h00, 4'b0100, 1'b0);
            if (i == 0) begin
                chk("catch_state", 32'(state), 32'd2);
                chk("catch_lives", 32'(lives), 32'd2);
            end
            if (i == 119) chk("death_hold", 32'(state), 32'd2);
            if (i == 120) begin
                chk("death_exit_state", 32'(state), 32'd0);
                chk("death_exit_respawn", 32'(respawn), 32'd1);
                chk("death_exit_patrol", 32'(patrol), 32'hE);
            end
            if (i == 121) chk("respawn_one_frame", 32'(respawn), 32'd0);
        end
        chk("catch_once_lives", 32'(lives), 32'd2);

        // second death with a start key held through DEATH
        step(8'h04, 4'b0, 1'b0);
        step(8'h00, 4'b0001, 1'b0);
        chk("catch2_lives", 32'(lives), 32'd1);
        for (int i = 0; i < 120; i++) step(8'h16, 4'b0, 1'b0);
        chk("held_key_ready", 32'(state), 32'd0);
        step(8'h16, 4'b0, 1'b0);
        chk("held_key_play", 32'(state), 32'd1);

        // third death ends the game
        step(8'h00, 4'b0010, 1'b0);
        chk("catch3_lives", 32'(lives), 32'd0);
        idle(120, 4'b0);
        chk("lose_state", 32'(state), 32'd3);
        chk("lose_won", 32'(won), 32'd0);
        chk("lose_respawn", 32'(respawn), 32'd0);
        step(8'h04, 4'b0, 1'b0);
        chk("end_ignores_key", 32'(state), 32'd3);
        step(8'h28, 4'b0, 1'b0);
        chk("restart_state", 32'(state), 32'd0);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_respawn", 32'(respawn), 32'd1);
        idle(1, 4'b0);

        // board clear beats a catch in the same frame
        step(8'h07, 4'b0, 1'b0);
        step(8'h00, 4'b0001, 1'b1);
        chk("win_state", 32'(state), 32'd3);
        chk("win_won", 32'(won), 32'd1);
        chk("win_lives", 32'(lives), 32'd3);
        step(8'h28, 4'b0, 1'b0);

        // async reset mid-DEATH with the countdown at 50
        step(8'h1A, 4'b0, 1'b0);
        step(8'h00, 4'b1000, 1'b0);
        idle(70, 4'b1000);
        chk("death_no_redec", 32'(lives), 32'd2);
        #3;
        Reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        model_reset();
        #2;
        Reset = 1'b0;
        idle(5, 4'b0);
        chk("post_rst_frozen", 32'(patrol), 32'hE);
        step(8'h04, 4'b0, 1'b0);
        idle(419, 4'b0);
        chk("post_rst_scatter", 32'(patrol), 32'hE);
        idle(1, 4'b0);
        chk("post_rst_chase", 32'(patrol), 32'h0);

        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
